// File: rtl/btn_pkg.sv
// btn_pkg: shared constants for the push-button write-strobe front end.
//   - Default debounce length: 10 ms at 100 MHz.
//   - FSM state encodings. These are kept as fixed 3-bit constants so that
//     legacy code and waveform viewers see the same state values.
package btn_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PRESS_DB   = 3'd1;
    localparam logic [2:0] ST_STROBE     = 3'd2;
    localparam logic [2:0] ST_HELD       = 3'd3;
    localparam logic [2:0] ST_RELEASE_DB = 3'd4;

endpackage

// File: rtl/btn_write_strobe_if.sv
// btn_write_strobe_if: groups the button, switch, and write-strobe signals.
//   btn_raw      raw push-button level (asynchronous)
//   data_in      switch data word, sampled when a strobe is issued
//   sel_in       bank select, sampled when a strobe is issued
//   wr_en        one-cycle write strobe per debounced press
//   wr_data      captured data, held until the next strobe
//   wr_sel       captured select, held until the next strobe
//   busy         FSM is not idle
//   press_count  strobes issued, modulo 256
// The master modport drives the button and switches. The slave modport is the
// strobe generator.
interface btn_write_strobe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 2
);
    logic              btn_raw;
    logic [DATA_W-1:0] data_in;
    logic [SEL_W-1:0]  sel_in;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [SEL_W-1:0]  wr_sel;
    logic              busy;
    logic [7:0]        press_count;

    modport master (
        output btn_raw, data_in, sel_in,
        input  wr_en, wr_data, wr_sel, busy, press_count
    );

    modport slave (
        input  btn_raw, data_in, sel_in,
        output wr_en, wr_data, wr_sel, busy, press_count
    );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for an asynchronous input.
//   clk    destination clock
//   reset  asynchronous, active-high; clears both flops
//   d      asynchronous input
//   q      synchronised output, two clock edges after d
// The design places no logic between the two flops, so the metastability
// window stays clean.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/btn_write_strobe.sv
// btn_write_strobe: synchronises and debounces a raw push-button. It emits
// exactly one single-cycle write strobe per clean press. On that strobe it
// captures the switch data word and the bank select for the downstream latch
// bank.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    btn_write_strobe_if.slave carrying
//          btn_raw, data_in, sel_in (inputs) and
//          wr_en, wr_data, wr_sel, busy, press_count (outputs)
// Parameters: DEBOUNCE_CYCLES (>=2) is the stable-level length for both press
// and release. DATA_W and SEL_W are the captured widths.
module btn_write_strobe
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned SEL_W           = 2
) (
    input logic               clk,
    input logic               reset,
    btn_write_strobe_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              btn_s;
    logic [2:0]        state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              wr_en_d, wr_en_q;
    logic [DATA_W-1:0] wr_data_d, wr_data_q;
    logic [SEL_W-1:0]  wr_sel_d, wr_sel_q;
    logic [7:0]        press_count_d, press_count_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.btn_raw),
        .q     (btn_s)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;        // counter restarts on every state entry
        wr_data_d     = wr_data_q;
        wr_sel_d      = wr_sel_q;
        press_count_d = press_count_q;
        // The strobe is registered from STROBE. It is asserted in the cycle
        // after that state, alongside the press_count update.
        wr_en_d       = (state_q == ST_STROBE);

        case (state_q)
            ST_IDLE: begin
                if (btn_s) state_d = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_STROBE;
                    wr_data_d = bus.data_in;
                    wr_sel_d  = bus.sel_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STROBE: begin
                state_d       = ST_HELD;
                press_count_d = press_count_q + 8'd1;
            end
            ST_HELD: begin
                if (!btn_s) state_d = ST_RELEASE_DB;
            end
            ST_RELEASE_DB: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            wr_sel_q      <= '0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            wr_sel_q      <= wr_sel_d;
            press_count_q <= press_count_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_sel      = wr_sel_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.press_count = press_count_q;
endmodule

// File: tb/tb_btn_write_strobe.sv
// tb_btn_write_strobe: directed scenarios plus random button activity. The
// behavioural model is based on run lengths: a press is accepted after
// DB+1 consecutive synchronised high samples, and a release after DB+1
// consecutive low samples. The strobe and the count update follow one cycle
// later.
module tb_btn_write_strobe;
    localparam int unsigned DB = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned SW = 2;
    localparam int          RUN_NEED = DB + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    btn_write_strobe_if #(.DATA_W(DW), .SEL_W(SW)) bus();

    btn_write_strobe #(
        .DEBOUNCE_CYCLES (DB),
        .DATA_W          (DW),
        .SEL_W           (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_STROBE, M_HELD} mphase_t;
    mphase_t    phase;
    bit         r1, r2;       // raw samples from the previous one and two edges
    int         run;
    logic [7:0] m_data;
    logic [1:0] m_sel;
    logic [7:0] m_count;
    bit         m_wr_en;

    int cyc = 0;
    int strobes_seen = 0;
    int first_strobe_cyc = -1;

    function automatic void model_reset();
        r1 = 1'b0; r2 = 1'b0; run = 0; phase = M_IDLE;
        m_data = '0; m_sel = '0; m_count = '0; m_wr_en = 1'b0;
    endfunction

    function automatic void model_step();
        bit s;
        s  = r2;
        r2 = r1;
        r1 = bus.btn_raw;
        m_wr_en = 1'b0;
        case (phase)
            M_IDLE: begin
                run = s ? run + 1 : 0;
                if (run == RUN_NEED) begin
                    phase  = M_STROBE;
                    run    = 0;
                    m_data = bus.data_in;
                    m_sel  = bus.sel_in;
                end
            end
            M_STROBE: begin
                phase   = M_HELD;
                m_wr_en = 1'b1;
                m_count = m_count + 8'd1;
            end
            M_HELD: begin
                run = s ? 0 : run + 1;
                if (run == RUN_NEED) begin
                    phase = M_IDLE;
                    run   = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic bit m_busy();
        return !(phase == M_IDLE && run == 0);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!reset) model_step();
        #1;
        if (bus.wr_en === 1'b1) begin
            strobes_seen++;
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
        end
        check_eq("wr_en",       32'(bus.wr_en),       32'(m_wr_en));
        check_eq("busy",        32'(bus.busy),        32'(m_busy()));
        check_eq("wr_data",     32'(bus.wr_data),     32'(m_data));
        check_eq("wr_sel",      32'(bus.wr_sel),      32'(m_sel));
        check_eq("press_count", 32'(bus.press_count), 32'(m_count));
    endtask

    task automatic hold(input logic b, input int n);
        bus.btn_raw = b;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_wr_en",       32'(bus.wr_en),       32'd0);
        check_eq("rst_busy",        32'(bus.busy),        32'd0);
        check_eq("rst_wr_data",     32'(bus.wr_data),     32'd0);
        check_eq("rst_wr_sel",      32'(bus.wr_sel),      32'd0);
        check_eq("rst_press_count", 32'(bus.press_count), 32'd0);
        repeat (n) tick();
        reset = 1'b0;
    endtask

    int s0;
    int k;
    int lvl;
    int n;

    initial begin
        bus.btn_raw = 1'b0;
        bus.data_in = '0;
        bus.sel_in  = '0;
        model_reset();
        #2;
        do_reset(3);

        // 1: clean press, latency and capture
        bus.data_in = 8'hA5;
        bus.sel_in  = 2'b10;
        s0 = strobes_seen;
        first_strobe_cyc = -1;
        k = cyc + 1;
        hold(1'b1, 20);
        check_eq("t1_latency", 32'(first_strobe_cyc - k), 32'd7);
        check_eq("t1_strobes", 32'(strobes_seen - s0), 32'd1);
        check_eq("t1_data", 32'(bus.wr_data), 32'hA5);
        check_eq("t1_sel",  32'(bus.wr_sel),  32'h2);
        check_eq("t1_count", 32'(bus.press_count), 32'd1);
        hold(1'b0, 12);

        // 2: short bouncing pulses are rejected
        s0 = strobes_seen;
        for (int i = 0; i < 2; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
        hold(1'b0, 10);
        check_eq("t2_strobes", 32'(strobes_seen - s0), 32'd0);
        check_eq("t2_busy", 32'(bus.busy), 32'd0);
        check_eq("t2_count", 32'(bus.press_count), 32'd1);

        // 3: long hold and switch change while held
        s0 = strobes_seen;
        hold(1'b1, 15);
        bus.data_in = 8'h3C;
        hold(1'b1, 35);
        hold(1'b0, 12);
        check_eq("t3_strobes", 32'(strobes_seen - s0), 32'd1);
        check_eq("t3_data", 32'(bus.wr_data), 32'hA5);

        // 4: release glitch does not re-strobe
        s0 = strobes_seen;
        hold(1'b1, 15);
        hold(1'b0, 2);
        hold(1'b1, 1);
        hold(1'b0, 20);
        check_eq("t4_strobes", 32'(strobes_seen - s0), 32'd1);
        check_eq("t4_data", 32'(bus.wr_data), 32'h3C);
        check_eq("t4_busy", 32'(bus.busy), 32'd0);

        // 5: 256 presses wrap press_count to 0
        do_reset(2);
        s0 = strobes_seen;
        for (int i = 0; i < 256; i++) begin
            bus.data_in = 8'($urandom);
            bus.sel_in  = 2'($urandom);
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        check_eq("t5_strobes", 32'(strobes_seen - s0), 32'd256);
        check_eq("t5_wrap", 32'(bus.press_count), 32'd0);

        // 6: reset during press debounce, then quiet
        hold(1'b1, 4);
        bus.btn_raw = 1'b0;
        do_reset(3);
        s0 = strobes_seen;
        hold(1'b0, 20);
        check_eq("t6_strobes", 32'(strobes_seen - s0), 32'd0);

        // button already high while reset releases: one strobe after debounce
        bus.btn_raw = 1'b1;
        do_reset(3);
        s0 = strobes_seen;
        hold(1'b1, 12);
        hold(1'b0, 12);
        check_eq("t7_strobes", 32'(strobes_seen - s0), 32'd1);
        check_eq("t7_count", 32'(bus.press_count), 32'd1);

        // random button activity with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.data_in = 8'($urandom);
                bus.sel_in  = 2'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end
            lvl = int'($urandom_range(0, 1));
            n   = int'($urandom_range(1, 9));
            hold(lvl[0], n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
